// File: rtl/risc16_lsu.sv
// risc16 load/store unit: in-order store buffer draining to data memory,
// registered loads with youngest-store forwarding.
module risc16_lsu #(
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        sb_empty,
    output logic [15:0] mem_access_addr,
    output logic [15:0] mem_write_data,
    output logic        mem_write_en,
    output logic        mem_read,
    input  logic [15:0] mem_read_data
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0] FULL_CNT = (IW+1)'(DEPTH);
    localparam logic [IW:0] ONE = (IW+1)'(1);

    logic [IW:0]   head;
    logic [IW:0]   tail;
    logic [IW:0]   count;
    logic [IW:0]   idx;
    logic [15:0]   sb_addr [DEPTH];
    logic [15:0]   sb_data [DEPTH];
    logic          full;
    logic          empty;
    logic          load;
    logic          store;
    logic          drain;
    logic [15:0]   fwd_data;
    logic [IW-1:0] head_idx;
    logic [IW-1:0] tail_idx;

    assign count    = tail - head;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign sb_empty = empty;
    assign req_ready = !full;
    assign head_idx = head[IW-1:0];
    assign tail_idx = tail[IW-1:0];

    // Reset gates the memory port so buffered stores never leak out.
    assign load  = req_valid && req_ready && !req_we && !reset;
    assign store = req_valid && req_ready && req_we && !reset;
    assign drain = !load && !empty && !reset;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_data = mem_read_data;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + (IW+1)'(i);
            if (((IW+1)'(i) < count) &&
                (sb_addr[idx[IW-1:0]][AW-1:0] == req_addr[AW-1:0])) begin
                fwd_data = sb_data[idx[IW-1:0]];
            end
        end
    end

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (load) begin
            mem_access_addr = req_addr;
            mem_read        = 1'b1;
        end else if (drain) begin
            mem_access_addr = sb_addr[head_idx];
            mem_write_data  = sb_data[head_idx];
            mem_write_en    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= load;
            if (load) begin
                rsp_rdata <= fwd_data;
            end
            if (drain) begin
                head <= head + ONE;
            end
            if (store) begin
                tail <= tail + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store) begin
            sb_addr[tail_idx] <= req_addr;
            sb_data[tail_idx] <= req_wdata;
        end
    end

endmodule

// File: tb/tb_risc16_lsu.sv
// Bench for risc16_lsu: directed scenarios plus random traffic against
// a queue/array reference of the store buffer and data memory.
module tb_risc16_lsu;
    localparam int DEPTH = 4;
    localparam int AW    = 3;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        sb_empty;
    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic        mem_read;
    logic [15:0] mem_read_data;

    int n_vec;
    int n_err;

    logic [15:0] tb_mem  [8];
    logic [15:0] ref_mem [8];
    logic [15:0] arch_mem[8];
    logic [31:0] q[$];
    logic        exp_rv;
    logic [15:0] exp_rd;

    risc16_lsu #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .sb_empty(sb_empty),
        .mem_access_addr(mem_access_addr),
        .mem_write_data(mem_write_data),
        .mem_write_en(mem_write_en),
        .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = tb_mem[mem_access_addr[2:0]];

    always @(posedge clk) begin
        if (mem_write_en) tb_mem[mem_access_addr[2:0]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, return at the following falling edge.
    task automatic step(input logic r, input logic v, input logic we,
                        input logic [15:0] a, input logic [15:0] d);
        @(posedge clk);
        #1;
        reset     = r;
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        @(negedge clk);
    endtask

    // Reference: queue of buffered stores, the memory as drained, and the
    // architectural memory a load must observe.
    initial begin : compare
        logic ld, st, dr, rdy;
        logic [15:0] e_addr, e_wdata;
        logic e_we, e_rd;
        logic [31:0] h;
        forever begin
            @(negedge clk);
            rdy = (q.size() < DEPTH);
            ld  = req_valid && rdy && !req_we && !reset;
            st  = req_valid && rdy && req_we && !reset;
            dr  = !ld && (q.size() > 0) && !reset;
            e_addr = 16'h0; e_wdata = 16'h0; e_we = 1'b0; e_rd = 1'b0;
            if (ld) begin
                e_addr = req_addr;
                e_rd   = 1'b1;
            end else if (dr) begin
                h       = q[0];
                e_addr  = h[31:16];
                e_wdata = h[15:0];
                e_we    = 1'b1;
            end
            chk("req_ready", 16'(req_ready), 16'(rdy));
            chk("sb_empty", 16'(sb_empty), 16'(q.size() == 0));
            chk("mem_read", 16'(mem_read), 16'(e_rd));
            chk("mem_write_en", 16'(mem_write_en), 16'(e_we));
            chk("mem_access_addr", mem_access_addr, e_addr);
            chk("mem_write_data", mem_write_data, e_wdata);
            chk("rsp_valid", 16'(rsp_valid), 16'(exp_rv));
            if (exp_rv) chk("rsp_rdata", rsp_rdata, exp_rd);
            @(posedge clk);
            if (reset) begin
                q.delete();
                exp_rv = 1'b0;
                exp_rd = 16'h0;
                for (int i = 0; i < 8; i++) arch_mem[i] = ref_mem[i];
            end else begin
                exp_rv = ld;
                if (ld) exp_rd = arch_mem[req_addr[2:0]];
                if (dr) begin
                    h = q.pop_front();
                    ref_mem[h[18:16]] = h[15:0];
                end
                if (st) begin
                    q.push_back({req_addr, req_wdata});
                    arch_mem[req_addr[2:0]] = req_wdata;
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_rv = 1'b0;
        exp_rd = 16'h0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = 16'h0;
        req_wdata = 16'h0;
        for (int i = 0; i < 8; i++) begin
            tb_mem[i]   = 16'h0;
            ref_mem[i]  = 16'h0;
            arch_mem[i] = 16'h0;
        end
        tb_mem[3]   = 16'h1234;
        ref_mem[3]  = 16'h1234;
        arch_mem[3] = 16'h1234;

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rst_rsp_rdata", rsp_rdata, 16'h0);
        chk("rst_sb_empty", 16'(sb_empty), 16'h1);
        chk("rst_req_ready", 16'(req_ready), 16'h1);
        chk("rst_mem_idle", {mem_write_en, mem_read, 14'h0}, 16'h0);
        chk("rst_mem_addr", mem_access_addr, 16'h0);

        step(0, 1, 0, 16'h3, 0);
        chk("ld3_mem_read", 16'(mem_read), 16'h1);
        chk("ld3_addr", mem_access_addr, 16'h3);
        step(0, 0, 0, 0, 0);
        chk("ld3_rsp_valid", 16'(rsp_valid), 16'h1);
        chk("ld3_rdata", rsp_rdata, 16'h1234);
        chk("ld3_read_drop", 16'(mem_read), 16'h0);

        step(0, 1, 1, 16'h5, 16'hBEEF);
        chk("st5_no_write_yet", 16'(mem_write_en), 16'h0);
        step(0, 0, 0, 0, 0);
        chk("st5_we", 16'(mem_write_en), 16'h1);
        chk("st5_addr", mem_access_addr, 16'h5);
        chk("st5_data", mem_write_data, 16'hBEEF);
        step(0, 0, 0, 0, 0);
        chk("st5_empty", 16'(sb_empty), 16'h1);
        chk("st5_we_once", 16'(mem_write_en), 16'h0);
        step(0, 1, 0, 16'h5, 0);
        step(0, 0, 0, 0, 0);
        chk("ld5_rdata", rsp_rdata, 16'hBEEF);

        step(0, 1, 1, 16'h2, 16'h0001);
        step(0, 1, 0, 16'h2, 0);
        step(0, 1, 1, 16'h2, 16'h0002);
        chk("fwd1_rdata", rsp_rdata, 16'h0001);
        step(0, 1, 0, 16'h2, 0);
        step(0, 1, 0, 16'h000A, 0);
        chk("fwd2_rdata", rsp_rdata, 16'h0002);
        step(0, 0, 0, 0, 0);
        chk("fwd_alias_rdata", rsp_rdata, 16'h0002);
        step(0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) step(0, 1, 1, 16'(i % 8), 16'hA000 + 16'(i));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        chk("wrap_mem0", tb_mem[0], 16'hA008);
        chk("wrap_mem1", tb_mem[1], 16'hA009);
        chk("wrap_mem5", tb_mem[5], 16'hA005);
        chk("wrap_mem7", tb_mem[7], 16'hA007);

        step(0, 1, 1, 16'h4, 16'h7777);
        step(0, 1, 0, 16'h0, 0);
        step(1, 0, 0, 0, 0);
        chk("rstmid_no_write", 16'(mem_write_en), 16'h0);
        step(0, 0, 0, 0, 0);
        chk("rstmid_rsp_valid", 16'(rsp_valid), 16'h0);
        chk("rstmid_sb_empty", 16'(sb_empty), 16'h1);
        chk("rstmid_we", 16'(mem_write_en), 16'h0);
        step(0, 0, 0, 0, 0);
        chk("rstmid_mem4", tb_mem[4], 16'hA004);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) a[15:3] = 13'($urandom);
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, a, 16'($urandom));
        end
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
